// File: rtl/ser_cmd_seq.sv
// ser_cmd_seq: frames command packets from the serial byte receiver.
//
// A packet is an opcode byte followed by 0-3 payload bytes. The payload
// length N comes from opcode bits [7:6]. Each complete packet is held on
// cmd_op/cmd_arg with cmd_valid high until downstream accepts it with
// cmd_ready. A partial packet is abandoned if no byte arrives within
// TIMEOUT_CLOCKS clocks.
//
// Optional build macro: SER_CMD_CHECKSUM_EN
//   When defined, every packet carries one trailing checksum byte. It must
//   equal the XOR of the opcode and all payload bytes. When undefined,
//   there is no checksum byte and err_checksum is tied to 0.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   rcv_full     one-cycle strobe: rcv_data holds a new byte
//   rcv_data     received byte
//   cmd_valid    complete packet available (registered)
//   cmd_ready    downstream accepts packet when cmd_valid && cmd_ready
//   cmd_op       opcode byte
//   cmd_arg      payload, little-endian, unused bytes zero
//   err_overrun  one-cycle pulse: byte dropped while a packet was held
//   err_timeout  one-cycle pulse: partial packet abandoned
//   err_checksum one-cycle pulse: checksum mismatch
module ser_cmd_seq #(
    parameter int unsigned TIMEOUT_CLOCKS = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rcv_full,
    input  logic [7:0]  rcv_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [23:0] cmd_arg,
    output logic        err_overrun,
    output logic        err_timeout,
    output logic        err_checksum
);

`ifdef SER_CMD_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_HOLD, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_HOLD} state_t;
`endif

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLOCKS - 1);

    state_t      state_q, state_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_op_q, cmd_op_d;
    logic [23:0] cmd_arg_q, cmd_arg_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_overrun_q, err_overrun_d;
    logic        err_timeout_q, err_timeout_d;
    logic        take_op;
    logic        expire;
`ifdef SER_CMD_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        err_checksum_q, err_checksum_d;
`endif

    assign expire = (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        cmd_op_d      = cmd_op_q;
        cmd_arg_d     = cmd_arg_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        err_overrun_d = 1'b0;
        err_timeout_d = 1'b0;
        take_op       = 1'b0;
`ifdef SER_CMD_CHECKSUM_EN
        csum_d         = csum_q;
        err_checksum_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (rcv_full) take_op = 1'b1;
            end
            S_PAYLOAD: begin
                if (rcv_full) begin
                    cmd_arg_d[{idx_q, 3'b000} +: 8] = rcv_data;
                    idx_d = idx_q + 2'd1;
                    cnt_d = '0;
`ifdef SER_CMD_CHECKSUM_EN
                    csum_d = csum_q ^ rcv_data;
                    if (({1'b0, idx_q} + 3'd1) == {1'b0, cmd_op_q[7:6]}) state_d = S_CHECK;
`else
                    if (({1'b0, idx_q} + 3'd1) == {1'b0, cmd_op_q[7:6]}) state_d = S_HOLD;
`endif
                end else if (expire) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HOLD: begin
                // A byte arriving on the handshake cycle starts the next packet.
                if (cmd_ready) begin
                    state_d = S_IDLE;
                    if (rcv_full) take_op = 1'b1;
                end else if (rcv_full) begin
                    err_overrun_d = 1'b1;
                end
            end
`ifdef SER_CMD_CHECKSUM_EN
            S_CHECK: begin
                if (rcv_full) begin
                    if (rcv_data == csum_q) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d        = S_IDLE;
                        err_checksum_d = 1'b1;
                    end
                end else if (expire) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (take_op) begin
            cmd_op_d  = rcv_data;
            cmd_arg_d = '0;
            idx_d     = '0;
            cnt_d     = '0;
`ifdef SER_CMD_CHECKSUM_EN
            csum_d  = rcv_data;
            state_d = (rcv_data[7:6] == 2'd0) ? S_CHECK : S_PAYLOAD;
`else
            state_d = (rcv_data[7:6] == 2'd0) ? S_HOLD : S_PAYLOAD;
`endif
        end

        cmd_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_arg_q     <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef SER_CMD_CHECKSUM_EN
            csum_q         <= '0;
            err_checksum_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_arg_q     <= cmd_arg_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
`ifdef SER_CMD_CHECKSUM_EN
            csum_q         <= csum_d;
            err_checksum_q <= err_checksum_d;
`endif
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_arg     = cmd_arg_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;
`ifdef SER_CMD_CHECKSUM_EN
    assign err_checksum = err_checksum_q;
`else
    assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_ser_cmd_seq.sv
// Testbench for ser_cmd_seq: directed byte sequences, a packet-level model
// compared against the outputs every cycle, and literal expectations.
module tb_ser_cmd_seq;
    localparam int unsigned TO = 100;
`ifdef SER_CMD_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rcv_full;
    logic [7:0]  rcv_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [23:0] cmd_arg;
    logic        err_overrun;
    logic        err_timeout;
    logic        err_checksum;

    always #5 clk = ~clk;

    ser_cmd_seq #(.TIMEOUT_CLOCKS(TO)) dut (
        .clk(clk), .reset(reset), .rcv_full(rcv_full), .rcv_data(rcv_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .err_overrun(err_overrun), .err_timeout(err_timeout),
        .err_checksum(err_checksum)
    );

    int checks = 0;
    int errors = 0;

    // Packet-level model: bytes of the packet being assembled, plus the
    // packet currently offered downstream.
    bit          m_valid;
    logic [7:0]  m_op;
    logic [23:0] m_arg;
    bit          m_eo, m_et, m_ec;
    logic [7:0]  q[$];
    int          silent;
    logic [7:0]  cs_sink;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void try_finish();
        logic [7:0] x;
        if (q.size() == int'(m_op[7:6]) + 1 + CS) begin
            if (CS == 1) begin
                x = 8'h00;
                for (int i = 0; i < q.size() - 1; i++) x = x ^ q[i];
                if (x == q[q.size()-1]) m_valid = 1'b1;
                else m_ec = 1'b1;
            end else begin
                m_valid = 1'b1;
            end
            q.delete();
        end
    endfunction

    function automatic void start_pkt(input logic [7:0] d);
        m_op   = d;
        m_arg  = '0;
        silent = 0;
        q.delete();
        q.push_back(d);
        try_finish();
    endfunction

    function automatic void add_byte(input logic [7:0] d);
        int idx;
        q.push_back(d);
        idx = q.size() - 2;
        if (idx < int'(m_op[7:6])) m_arg[8*idx +: 8] = d;
        silent = 0;
        try_finish();
    endfunction

    function automatic void model_step();
        m_eo = 1'b0;
        m_et = 1'b0;
        m_ec = 1'b0;
        if (!reset) begin
            m_valid = 1'b0;
            m_op    = '0;
            m_arg   = '0;
            silent  = 0;
            q.delete();
        end else if (m_valid) begin
            if (cmd_ready) begin
                m_valid = 1'b0;
                if (rcv_full) start_pkt(rcv_data);
            end else if (rcv_full) begin
                m_eo = 1'b1;
            end
        end else if (q.size() == 0) begin
            if (rcv_full) start_pkt(rcv_data);
        end else if (rcv_full) begin
            add_byte(rcv_data);
        end else begin
            silent++;
            if (silent == int'(TO)) begin
                q.delete();
                m_et = 1'b1;
            end
        end
    endfunction

    // One clock: model advances on the edge, outputs compared 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
        chk("model err_overrun", {31'd0, err_overrun}, {31'd0, m_eo});
        chk("model err_timeout", {31'd0, err_timeout}, {31'd0, m_et});
        chk("model err_checksum", {31'd0, err_checksum}, {31'd0, m_ec});
        if (m_valid) begin
            chk("model cmd_op", {24'd0, cmd_op}, {24'd0, m_op});
            chk("model cmd_arg", {8'd0, cmd_arg}, {8'd0, m_arg});
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic rdy);
        rcv_full  = 1'b1;
        rcv_data  = d;
        cmd_ready = rdy;
        cycle();
        rcv_full  = 1'b0;
    endtask

    // Trailing checksum byte, only present when the feature is built in.
    task automatic send_cs(input logic [7:0] v, input logic rdy);
`ifdef SER_CMD_CHECKSUM_EN
        send_byte(v, rdy);
`else
        cs_sink = v ^ {7'd0, rdy};
`endif
    endtask

    initial begin
        reset     = 1'b0;
        rcv_full  = 1'b0;
        rcv_data  = 8'h00;
        cmd_ready = 1'b0;
        cs_sink   = 8'h00;
        m_valid   = 1'b0;
        m_op      = '0;
        m_arg     = '0;
        silent    = 0;
        repeat (2) cycle();
        chk("reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("reset cmd_op", {24'd0, cmd_op}, 32'd0);
        chk("reset cmd_arg", {8'd0, cmd_arg}, 32'd0);
        reset = 1'b1;
        cycle();

        // Zero-payload opcode, downstream ready.
        send_byte(8'h05, 1'b1);
        send_cs(8'h05, 1'b1);
        chk("op05 valid", {31'd0, cmd_valid}, 32'd1);
        chk("op05 op", {24'd0, cmd_op}, 32'h05);
        chk("op05 arg", {8'd0, cmd_arg}, 32'h0);
        cycle();
        chk("op05 drop", {31'd0, cmd_valid}, 32'd0);

        // Three payload bytes held while not ready.
        send_byte(8'hC1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_cs(8'hC1, 1'b0);
        chk("opC1 valid", {31'd0, cmd_valid}, 32'd1);
        chk("opC1 op", {24'd0, cmd_op}, 32'hC1);
        chk("opC1 arg", {8'd0, cmd_arg}, 32'h332211);
        repeat (3) cycle();
        chk("opC1 held", {31'd0, cmd_valid}, 32'd1);
        cmd_ready = 1'b1;
        cycle();
        chk("opC1 drop", {31'd0, cmd_valid}, 32'd0);
        cmd_ready = 1'b0;

        // Overrun while held, then byte coinciding with the handshake.
        send_byte(8'h05, 1'b0);
        send_cs(8'h05, 1'b0);
        send_byte(8'h07, 1'b0);
        chk("overrun pulse", {31'd0, err_overrun}, 32'd1);
        chk("overrun keeps op", {24'd0, cmd_op}, 32'h05);
        cycle();
        chk("overrun one cycle", {31'd0, err_overrun}, 32'd0);
        send_byte(8'h07, 1'b1);
        chk("handshake no overrun", {31'd0, err_overrun}, 32'd0);
        send_cs(8'h07, 1'b0);
        chk("op07 valid", {31'd0, cmd_valid}, 32'd1);
        chk("op07 op", {24'd0, cmd_op}, 32'h07);
        cmd_ready = 1'b1;
        cycle();

        // Timeout after TO silent clocks.
        send_byte(8'h81, 1'b1);
        repeat (TO - 1) cycle();
        chk("timeout not early", {31'd0, err_timeout}, 32'd0);
        cycle();
        chk("timeout pulse", {31'd0, err_timeout}, 32'd1);
        chk("timeout no valid", {31'd0, cmd_valid}, 32'd0);
        cycle();
        chk("timeout one cycle", {31'd0, err_timeout}, 32'd0);
        send_byte(8'h00, 1'b1);
        send_cs(8'h00, 1'b1);
        chk("op00 valid", {31'd0, cmd_valid}, 32'd1);
        chk("op00 op", {24'd0, cmd_op}, 32'h00);
        cycle();

        // Byte on the expiry cycle is accepted.
        send_byte(8'h81, 1'b1);
        repeat (TO - 1) cycle();
        send_byte(8'hAB, 1'b1);
        chk("expiry byte no timeout", {31'd0, err_timeout}, 32'd0);
        send_byte(8'hCD, 1'b1);
        send_cs(8'hE7, 1'b1);
        chk("op81 valid", {31'd0, cmd_valid}, 32'd1);
        chk("op81 arg", {8'd0, cmd_arg}, 32'h00CDAB);
        cycle();

        // Reset in the middle of a payload.
        send_byte(8'hC1, 1'b0);
        send_byte(8'h11, 1'b0);
        reset = 1'b0;
        cycle();
        chk("midreset valid", {31'd0, cmd_valid}, 32'd0);
        chk("midreset op", {24'd0, cmd_op}, 32'h0);
        chk("midreset arg", {8'd0, cmd_arg}, 32'h0);
        chk("midreset errs", {29'd0, err_overrun, err_timeout, err_checksum}, 32'd0);
        reset = 1'b1;
        send_byte(8'h00, 1'b0);
        send_cs(8'h00, 1'b0);
        chk("fresh op00 valid", {31'd0, cmd_valid}, 32'd1);
        chk("fresh op00 op", {24'd0, cmd_op}, 32'h00);
        cmd_ready = 1'b1;
        cycle();

`ifdef SER_CMD_CHECKSUM_EN
        send_byte(8'h41, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h51, 1'b1);
        chk("cs good valid", {31'd0, cmd_valid}, 32'd1);
        chk("cs good arg", {8'd0, cmd_arg}, 32'h000010);
        cycle();
        send_byte(8'h41, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h50, 1'b1);
        chk("cs bad pulse", {31'd0, err_checksum}, 32'd1);
        chk("cs bad no valid", {31'd0, cmd_valid}, 32'd0);
        cycle();
`endif
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_cmd_seq.md
Name: ser_cmd_seq

Overview:
Command sequencer behind the serial byte receiver. Consumes the receiver's one-cycle byte strobe and data, and frames variable-length command packets: an opcode byte followed by 0-3 payload bytes. Presents each complete packet to the GPU command logic over a valid/ready handshake. Detects overrun and inter-byte timeout.

Parameters:
TIMEOUT_CLOCKS, 1000000, max clocks between bytes of one packet before it is abandoned (4 byte times at 2 kbaud, 50 MHz); counter width 32 bits.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset (reset==0 resets on clk edge)
rcv_full  input  1  one-cycle strobe: rcv_data holds a new byte
rcv_data  input  8  received byte, valid when rcv_full==1
cmd_valid  output  1  complete packet available
cmd_ready  input  1  downstream accepts packet when cmd_valid&&cmd_ready
cmd_op  output  8  opcode byte
cmd_arg  output  24  payload, little-endian; unused bytes zero
err_overrun  output  1  one-cycle pulse: byte dropped while packet held
err_timeout  output  1  one-cycle pulse: partial packet abandoned
err_checksum  output  1  one-cycle pulse: checksum mismatch (0 when feature off)

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; cmd_valid=0, cmd_op=0, cmd_arg=0, all err_* =0, timeout counter=0, byte index=0. Reset mid-packet discards it with no error pulse.
- Payload length N = rcv_data[7:6] of opcode (0..3).
- IDLE: on rcv_full: cmd_op<=rcv_data, cmd_arg<=0, index<=0, counter<=0; N==0 -> HOLD, else PAYLOAD.
- PAYLOAD: on rcv_full: cmd_arg[8*index+7:8*index]<=rcv_data, index++, counter<=0; after byte N -> HOLD (or CHECK with feature). Without rcv_full: counter++; when counter==TIMEOUT_CLOCKS-1 -> IDLE, err_timeout pulse next cycle. rcv_full in expiry cycle wins: byte accepted, no timeout.
- HOLD: cmd_valid=1; cmd_op/cmd_arg stable until handshake. cmd_valid&&cmd_ready -> cmd_valid deasserts next cycle, state IDLE.
- Latency: cmd_valid rises the cycle after the final byte's rcv_full.
- rcv_full in HOLD without cmd_ready: byte dropped, err_overrun pulse, packet kept. With cmd_ready same cycle: handshake completes and byte is taken as the next opcode (IDLE rules), no overrun.
- No timeout in IDLE or HOLD; HOLD waits indefinitely.
- err_* are registered, one cycle wide; never asserted in consecutive cycles for one event.

Optional Feature:
SER_CMD_CHECKSUM_EN: defined -> after the last payload byte (or opcode if N==0) enter CHECK; next byte must equal XOR of opcode and all payload bytes. Match -> HOLD; mismatch -> IDLE, err_checksum pulse, no cmd_valid. Timeout applies in CHECK as in PAYLOAD. Undefined -> no CHECK state, err_checksum tied 0.

Test Plan:
- Bytes 0x05 (N=0), cmd_ready=1 -> cmd_valid one cycle after strobe, cmd_op=0x05, cmd_arg=0x000000.
- Bytes 0xC1,0x11,0x22,0x33, cmd_ready=0 -> cmd_valid held, cmd_op=0xC1, cmd_arg=0x332211; raise cmd_ready -> valid drops next cycle.
- Held packet, cmd_ready=0, byte 0x07 arrives -> err_overrun pulse, packet unchanged; repeat with cmd_ready=1 same cycle -> no overrun, 0x07 becomes next packet.
- Byte 0x81 then silence TIMEOUT_CLOCKS (small override, e.g. 100) -> err_timeout pulse, IDLE; byte 0x00 -> packet op=0x00; byte on expiry cycle -> accepted, no error.
- Reset low during PAYLOAD of 0xC1 after one byte -> all outputs 0, next 0x00 framed as fresh opcode.
- With SER_CMD_CHECKSUM_EN: 0x41,0x10,0x51 -> cmd_valid, arg=0x000010; 0x41,0x10,0x50 -> err_checksum pulse, no cmd_valid.
